message_rom_dec: RTL and testbench

Character source for the UART message printer. The block converts a 32-bit signed value into decimal ASCII with a sequential binary-to-BCD converter, and stores the digits in registers. It returns one character per address, combinationally, so the printer can walk the address down and stream characters to the UART transmitter. It sits between the printer FSM (which drives `addr`, `valuetoprint`, `isneg`, `startconv`) and the UART TX data input.

---
 rtl/message_rom_dec_if.sv | 29 ++
 rtl/message_rom_dec.sv | 141 ++++++++++++++
 tb/tb_message_rom_dec.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/message_rom_dec_if.sv
// rtl/message_rom_dec_if.sv - printer-side bus of the decimal message character source
//
// Purpose: groups the signals between the UART message printer and message_rom_dec.
// Signals:
//   addr           printer -> rom  8   character address (unsigned decode)
//   valuetoprint   printer -> rom  32  two's-complement value to render
//   isneg          printer -> rom  1   force the sign character to '-'
//   startconv      printer -> rom  1   level-sensitive conversion request
//   data           rom -> printer  8   ASCII character at addr
//   conversiondone rom -> printer  1   digits match the latched value
// Modports: master = printer, slave = message_rom_dec.
interface message_rom_dec_if;
  logic [7:0]  addr;
  logic [31:0] valuetoprint;
  logic        isneg;
  logic        startconv;
  logic [7:0]  data;
  logic        conversiondone;

  modport master (
    output addr, valuetoprint, isneg, startconv,
    input  data, conversiondone
  );

  modport slave (
    input  addr, valuetoprint, isneg, startconv,
    output data, conversiondone
  );
endinterface

// File: rtl/message_rom_dec.sv
// rtl/message_rom_dec.sv - 32-bit signed value to decimal ASCII character source
//
// Purpose: converts valuetoprint to ten BCD digits with a one-bit-per-clock
// double-dabble and serves the rendered message one character per address.
// Ports:
//   i_clk  in  1   system clock, rising edge
//   i_rst  in  1   asynchronous active-high reset
//   bus    slave modport of message_rom_dec_if (addr/valuetoprint/isneg/startconv in,
//          data/conversiondone out)
// Address map: 0 newline, 1..10 digits (addr k = 10^(k-1)), 11 sign, 12 space, else 0.
module message_rom_dec (
  input  logic                i_clk,
  input  logic                i_rst,
  message_rom_dec_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_v;         // latched value, compared against the input for auto-start
  logic        r_sign_lat;  // sign captured at start
  logic        r_sign_vis;  // sign shown on address 11
  logic [39:0] r_digits;    // visible digits D9..D0
  logic [39:0] r_bcd;       // conversion shadow
  logic [31:0] r_bin;       // magnitude being shifted out MSB first
  logic [4:0]  r_cnt;

  logic        w_start;
  logic [31:0] w_mag;
  logic [39:0] w_adj;
  logic [7:0]  w_data;

  // Add 3 to every BCD digit that is 5 or more, so the following shift carries correctly.
  function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int k = 0; k < 10; k++) begin
      if (r[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign w_start = (r_state == IDLE) && (bus.startconv || (bus.valuetoprint != r_v));
  // Two's-complement negate as unsigned: -2^31 maps onto 0x8000_0000.
  assign w_mag   = bus.valuetoprint[31] ? (~bus.valuetoprint + 32'd1) : bus.valuetoprint;
  assign w_adj   = dabble_adjust(r_bcd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    bus.conversiondone = 1'b0;
    case (r_state)
      IDLE: begin
        bus.conversiondone = 1'b1;
        if (w_start) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == 5'd31) begin
          w_next = COMMIT;
        end
      end
      COMMIT: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v        <= 32'd0;
      r_sign_lat <= 1'b0;
      r_sign_vis <= 1'b0;
      r_digits   <= 40'd0;
      r_bcd      <= 40'd0;
      r_bin      <= 32'd0;
      r_cnt      <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_v        <= bus.valuetoprint;
            r_sign_lat <= bus.isneg | bus.valuetoprint[31];
            r_bin      <= w_mag;
            r_bcd      <= 40'd0;
            r_cnt      <= 5'd0;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[38:0], r_bin[31]};
          r_bin <= {r_bin[30:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        COMMIT: begin
          r_digits   <= r_bcd;
          r_sign_vis <= r_sign_lat;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_data = 8'h00;
    if (bus.addr == 8'd0) begin
      w_data = 8'h0A;
    end else if (bus.addr == 8'd11) begin
      w_data = r_sign_vis ? 8'h2D : 8'h20;
    end else if (bus.addr == 8'd12) begin
      w_data = 8'h20;
    end else begin
      for (int k = 1; k <= 10; k++) begin
        if (bus.addr == 8'(k)) begin
          w_data = {4'h3, r_digits[4*(k-1) +: 4]};
        end
      end
    end
  end

  assign bus.data = w_data;

endmodule

// File: tb/tb_message_rom_dec.sv
// tb/tb_message_rom_dec.sv - self-checking bench for message_rom_dec
module tb_message_rom_dec;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cur_v;
  bit   cur_n;
  int   old_v;
  bit   old_n;
  int   cyc;

  message_rom_dec_if bus_if ();

  message_rom_dec dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Expected character from the address map, using decimal arithmetic on the value.
  function automatic logic [7:0] exp_char(int a, int val, bit neg);
    longint m;
    longint p;
    m = val;
    if (m < 0) m = -m;
    if (a == 0) return 8'h0A;
    if (a >= 1 && a <= 10) begin
      p = 1;
      for (int i = 0; i < a - 1; i++) p = p * 10;
      return 8'h30 + 8'((m / p) % 10);
    end
    if (a == 11) return (neg || val < 0) ? 8'h2D : 8'h20;
    if (a == 12) return 8'h20;
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_map(string tag, int val, bit neg);
    int addrs [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 200};
    foreach (addrs[i]) begin
      bus_if.addr = 8'(addrs[i]);
      #1;
      chk($sformatf("%s_addr%0d", tag, addrs[i]), 32'(bus_if.data),
          32'(exp_char(addrs[i], val, neg)));
    end
  endtask

  // While busy, the previously committed rendering must remain visible.
  task automatic busy_check();
    bus_if.addr = 8'(cyc % 13);
    #1;
    chk("busy_stable", 32'(bus_if.data), 32'(exp_char(cyc % 13, old_v, old_n)));
  endtask

  task automatic wait_done(string tag);
    cyc = 0;
    while (bus_if.conversiondone !== 1'b1 && cyc < 100) begin
      busy_check();
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd33);
  endtask

  task automatic run_conv(string tag, int v, bit n, bit st);
    old_v = cur_v;
    old_n = cur_n;
    bus_if.valuetoprint = v;
    bus_if.isneg        = n;
    bus_if.startconv    = st;
    tick();
    bus_if.startconv = 1'b0;
    bus_if.isneg     = 1'($urandom % 2);
    chk({tag, "_done_low"}, 32'(bus_if.conversiondone), 32'd0);
    wait_done(tag);
    cur_v = v;
    cur_n = n;
    check_map(tag, v, n);
  endtask

  initial begin
    int v;
    bit n;
    bit st;
    tests = 0;
    fails = 0;
    cur_v = 0;
    cur_n = 1'b0;
    rst = 1'b1;
    bus_if.addr         = 8'd0;
    bus_if.valuetoprint = 32'd0;
    bus_if.isneg        = 1'b0;
    bus_if.startconv    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_done", 32'(bus_if.conversiondone), 32'd1);
    check_map("reset", 0, 1'b0);

    run_conv("pos48", 48, 1'b0, 1'b1);
    run_conv("p9999", 9999, 1'b0, 1'b1);
    run_conv("neg332952", -332952, 1'b0, 1'b1);
    run_conv("big", 2147483646, 1'b0, 1'b1);
    run_conv("minint", 32'h8000_0000, 1'b0, 1'b1);
    run_conv("auto1234", 1234, 1'b0, 1'b0);
    run_conv("forced_neg5", 5, 1'b1, 1'b1);
    run_conv("restart_same", 5, 1'b0, 1'b1);

    // Value change mid-conversion: converted next after a single done-high cycle.
    old_v = cur_v;
    old_n = cur_n;
    bus_if.valuetoprint = 4242;
    bus_if.isneg        = 1'b0;
    bus_if.startconv    = 1'b1;
    tick();
    bus_if.startconv = 1'b0;
    cyc = 0;
    repeat (10) begin
      busy_check();
      tick();
      cyc++;
    end
    bus_if.valuetoprint = -77;
    while (bus_if.conversiondone !== 1'b1 && cyc < 100) begin
      busy_check();
      tick();
      cyc++;
    end
    chk("midchg_latency", 32'(cyc), 32'd33);
    check_map("midchg_first", 4242, 1'b0);
    tick();
    chk("midchg_gap", 32'(bus_if.conversiondone), 32'd0);
    old_v = 4242;
    old_n = 1'b0;
    wait_done("midchg_second");
    cur_v = -77;
    cur_n = 1'b0;
    check_map("midchg_second", -77, 1'b0);

    // Reset in the middle of a conversion.
    bus_if.valuetoprint = 777;
    bus_if.isneg        = 1'b0;
    bus_if.startconv    = 1'b1;
    tick();
    bus_if.startconv = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("rstmid_done", 32'(bus_if.conversiondone), 32'd1);
    check_map("rstmid", 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    old_v = 0;
    old_n = 1'b0;
    tick();
    chk("rstmid_autostart", 32'(bus_if.conversiondone), 32'd0);
    wait_done("rstmid_777");
    cur_v = 777;
    cur_n = 1'b0;
    check_map("rstmid_777", 777, 1'b0);

    // Randomized values against the decimal model.
    for (int i = 0; i < 8; i++) begin
      v  = int'($urandom);
      st = 1'($urandom % 2);
      n  = ($urandom % 4) == 0;
      if (v == cur_v) st = 1'b1;
      run_conv($sformatf("rand%0d", i), v, n, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
